// File: rtl/piso_shift_if.sv
// Load/stream bundle for the serial-link transmitter: parallel word handshake in,
// serial bit stream with framing flags out.
interface piso_shift_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             bit_en;
    logic             ser_out;
    logic             ser_valid;
    logic             last;

    modport master (
        output d, load_valid, bit_en,
        input  load_ready, ser_out, ser_valid, last
    );

    modport slave (
        input  d, load_valid, bit_en,
        output load_ready, ser_out, ser_valid, last
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: LSB-first frames, one bit per bit_en cycle.
// Define PISO_PARITY_EN to append an even-parity bit after each data word.
module piso_shift_tx #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    piso_shift_if.slave bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] sh;
    logic [CNT_W-1:0]     count;
    logic                 ser_out_r;
    logic                 ser_valid_r;
    logic                 last_r;
    logic                 frame_end;
    logic                 accept;
    logic [FRAME_LEN-1:0] new_frame;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    // The final bit's enabled edge doubles as the load slot for the next word.
    assign frame_end      = (state == SHIFT) && last_r && bus.bit_en;
    assign bus.load_ready = rst_n && ((state == IDLE) || frame_end);
    assign accept         = bus.load_valid && bus.load_ready;
    assign new_frame      = build_frame(bus.d);

    assign bus.ser_out    = ser_out_r;
    assign bus.ser_valid  = ser_valid_r;
    assign bus.last       = last_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh          <= '0;
            count       <= '0;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SHIFT;
                        ser_out_r   <= new_frame[0];
                        sh          <= new_frame >> 1;
                        count       <= '0;
                        ser_valid_r <= 1'b1;
                        last_r      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        if (last_r) begin
                            if (bus.load_valid) begin
                                ser_out_r   <= new_frame[0];
                                sh          <= new_frame >> 1;
                                count       <= '0;
                                ser_valid_r <= 1'b1;
                                last_r      <= 1'b0;
                            end else begin
                                state       <= IDLE;
                                ser_out_r   <= 1'b0;
                                ser_valid_r <= 1'b0;
                                last_r      <= 1'b0;
                            end
                        end else begin
                            // sh holds the not-yet-sent bits with the next one at bit 0.
                            ser_out_r <= sh[0];
                            sh        <= sh >> 1;
                            count     <= count + 1'b1;
                            last_r    <= ((count + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: random-driven frames checked against a bit-index model.
module tb_piso_shift_tx;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    piso_shift_if #(.WIDTH(W)) bus ();
    piso_shift_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Bit i of the frame carrying word w: data LSB first, then parity if enabled.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[i];
        return ^w;
    endfunction

    task automatic drive(input logic v, input logic en, input logic [W-1:0] dv);
        bus.load_valid = v;
        bus.bit_en     = en;
        bus.d          = dv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 4'hF);
        tick();
        checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("FAIL reset ser_out: got %b required 0", bus.ser_out); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL reset ser_valid: got %b required 0", bus.ser_valid); end
        checks++; if (bus.last !== 1'b0) begin errors++; $display("FAIL reset last: got %b required 0", bus.last); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset load_ready: got %b required 0", bus.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL release load_ready: got %b required 1", bus.load_ready); end
        drive(1'b0, 1'b0, '0);
    endtask

    // mode 0: bit_en always high; 1: one cycle in three; 2: random
    task automatic test_stream(input logic [W-1:0] word, input int mode, input string name);
        int   idx;
        logic en;
        logic v;
        logic want_rdy;
        drive(1'b1, 1'b0, word);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL %s idle load_ready: got %b required 1", name, bus.load_ready); end
        tick();
        idx = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            checks++; if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL %s ser_valid bit%0d: got %b required 1", name, idx, bus.ser_valid); end
            checks++; if (bus.ser_out !== exp_bit(word, idx)) begin errors++; $display("FAIL %s ser_out bit%0d: got %b required %b", name, idx, bus.ser_out, exp_bit(word, idx)); end
            checks++; if (bus.last !== (idx == FLEN - 1)) begin errors++; $display("FAIL %s last bit%0d: got %b required %b", name, idx, bus.last, (idx == FLEN - 1)); end
            if (mode == 0)      en = 1'b1;
            else if (mode == 1) en = (cyc % 3 == 2);
            else                en = 1'($urandom_range(0, 1));
            want_rdy = (idx == FLEN - 1) && en;
            v = want_rdy ? 1'b0 : 1'($urandom_range(0, 1));
            drive(v, en, W'($urandom));
            checks++; if (bus.load_ready !== want_rdy) begin errors++; $display("FAIL %s load_ready bit%0d: got %b required %b", name, idx, bus.load_ready, want_rdy); end
            tick();
            if (en) idx++;
            if (idx == FLEN) break;
        end
        checks++; if (idx != FLEN) begin errors++; $display("FAIL %s frame_done: got %0d bits required %0d", name, idx, FLEN); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL %s end ser_valid: got %b required 0", name, bus.ser_valid); end
        checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("FAIL %s end ser_out: got %b required 0", name, bus.ser_out); end
        checks++; if (bus.last !== 1'b0) begin errors++; $display("FAIL %s end last: got %b required 0", name, bus.last); end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        logic         more;
        words[0] = 4'b1011;
        words[1] = 4'b0100;
        words[2] = W'($urandom);
        drive(1'b1, 1'b1, words[0]);
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                checks++; if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL b2b ser_valid f%0d b%0d: got %b required 1", f, i, bus.ser_valid); end
                checks++; if (bus.ser_out !== exp_bit(words[f], i)) begin errors++; $display("FAIL b2b ser_out f%0d b%0d: got %b required %b", f, i, bus.ser_out, exp_bit(words[f], i)); end
                checks++; if (bus.last !== (i == FLEN - 1)) begin errors++; $display("FAIL b2b last f%0d b%0d: got %b required %b", f, i, bus.last, (i == FLEN - 1)); end
                more = (f < 2);
                if (i == FLEN - 1) drive(more, 1'b1, more ? words[f + 1] : W'($urandom));
                else               drive(1'b1, 1'b1, W'($urandom));
                checks++; if (bus.load_ready !== (i == FLEN - 1)) begin errors++; $display("FAIL b2b load_ready f%0d b%0d: got %b required %b", f, i, bus.load_ready, (i == FLEN - 1)); end
                tick();
            end
        end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL b2b end ser_valid: got %b required 0", bus.ser_valid); end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_d_change();
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [W-1:0] cur;
        logic         en;
        logic         v;
        logic [W-1:0] dv;
        int           idx;
        int           frame;
        w0 = W'($urandom);
        w1 = ~w0;
        drive(1'b1, 1'b0, w0);
        tick();
        idx = 0; frame = 0; cur = w0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (bus.ser_out !== exp_bit(cur, idx)) begin errors++; $display("FAIL dchg ser_out f%0d b%0d: got %b required %b", frame, idx, bus.ser_out, exp_bit(cur, idx)); end
            checks++; if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL dchg ser_valid f%0d b%0d: got %b required 1", frame, idx, bus.ser_valid); end
            en = 1'($urandom_range(0, 1));
            if (frame == 0) begin
                v  = 1'b1;
                dv = ((idx == FLEN - 1) && en) ? w1 : W'($urandom);
            end else begin
                v  = !((idx == FLEN - 1) && en);
                dv = W'($urandom);
            end
            drive(v, en, dv);
            tick();
            if (en) idx++;
            if (idx == FLEN) begin
                if (frame == 1) break;
                frame = 1; cur = w1; idx = 0;
            end
        end
        checks++; if (idx != FLEN || frame != 1) begin errors++; $display("FAIL dchg done: got frame %0d bit %0d required frame 1 bit %0d", frame, idx, FLEN); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL dchg end ser_valid: got %b required 0", bus.ser_valid); end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_abort();
        logic [W-1:0] w;
        drive(1'b1, 1'b1, 4'b1111);
        tick();
        drive(1'b0, 1'b1, '0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("FAIL abort ser_out: got %b required 0", bus.ser_out); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL abort ser_valid: got %b required 0", bus.ser_valid); end
        checks++; if (bus.last !== 1'b0) begin errors++; $display("FAIL abort last: got %b required 0", bus.last); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL abort load_ready: got %b required 0", bus.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        w = 4'b0001;
        drive(1'b1, 1'b1, w);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL abort idle load_ready: got %b required 1", bus.load_ready); end
        tick();
        for (int i = 0; i < FLEN; i++) begin
            checks++; if (bus.ser_out !== exp_bit(w, i)) begin errors++; $display("FAIL abort ser_out b%0d: got %b required %b", i, bus.ser_out, exp_bit(w, i)); end
            checks++; if (bus.last !== (i == FLEN - 1)) begin errors++; $display("FAIL abort last b%0d: got %b required %b", i, bus.last, (i == FLEN - 1)); end
            drive(1'b0, 1'b1, W'($urandom));
            tick();
        end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL abort end ser_valid: got %b required 0", bus.ser_valid); end
        drive(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.bit_en     = 1'b0;
        bus.d          = '0;
        test_reset();
        test_stream(4'b1011, 0, "basic");
        test_stream(4'b0110, 1, "slow");
        for (int n = 0; n < 8; n++) test_stream(W'($urandom), 2, "random");
        test_back_to_back();
        test_d_change();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end
endmodule
